// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris game controller:
// FSM state enum, row-clear score table and board geometry.
package tetris_pkg;

    localparam int BOARD_ROWS = 23;
    localparam int BOARD_COLS = 10;

    // Points awarded per piece, indexed by rows cleared by that piece
    localparam logic [3:0] SCORE_K0 = 4'd0;
    localparam logic [3:0] SCORE_K1 = 4'd1;
    localparam logic [3:0] SCORE_K2 = 4'd3;
    localparam logic [3:0] SCORE_K3 = 4'd5;
    localparam logic [3:0] SCORE_K4 = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        NEW,
        SPAWN,
        FALL,
        LOCK,
        SCAN,
        SETTLE,
        SCORE,
        GAME_OVER
    } state_t;

    // Four or more rows in one lock all earn the top award
    function automatic logic [3:0] score_for(input logic [2:0] k);
        case (k)
            3'd0:    return SCORE_K0;
            3'd1:    return SCORE_K1;
            3'd2:    return SCORE_K2;
            3'd3:    return SCORE_K3;
            default: return SCORE_K4;
        endcase
    endfunction

endpackage

// File: rtl/tetris_sequencer_key_edge.sv
// Registers the three key levels and reports one-cycle rising edges.
// Ports: clock, reset, keys {rotate,right,left}, press {rotate,right,left}.
module key_edge (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] keys,
    output logic [2:0] press
);

    logic [2:0] keys_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            keys_q <= '0;
        end else begin
            keys_q <= keys;
        end
    end

    assign press = keys & ~keys_q;

endmodule

// File: rtl/tetris_sequencer.sv
// Game controller: spawn, gravity, moves, lock delay, row scan/clear,
// scoring and game over. Ports: clock/reset, start_game, fall_tick,
// key_*, datapath flags in; one-hot command pulses, scan_row, score,
// lines and game_over out (all registered).
module tetris_sequencer
    import tetris_pkg::*;
#(
    parameter int ROWS       = BOARD_ROWS,
    parameter int ROW_W      = 5,
    parameter int LOCK_TICKS = 2,
    parameter int SCORE_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_game,
    input  logic               fall_tick,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_rotate,
    input  logic               filled_under,
    input  logic               filled_left,
    input  logic               filled_right,
    input  logic               rotation_conflicts,
    input  logic               spawn_blocked,
    input  logic               row_full,
    output logic               clear_board,
    output logic               load_block,
    output logic               move_down,
    output logic               move_left,
    output logic               move_right,
    output logic               rotate,
    output logic               update_board_state,
    output logic [ROW_W-1:0]   scan_row,
    output logic               clear_row,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] lines,
    output logic               game_over
);

    localparam int LOCK_W = $clog2(LOCK_TICKS + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_TICKS);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

    state_t            state;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_next;
    logic [2:0]        clr_cnt;
    logic [2:0]        press;
    logic [SCORE_W:0]  score_sum;
    logic [SCORE_W:0]  lines_sum;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W-1:0] lines_next;

    key_edge u_key_edge (
        .clock (clock),
        .reset (reset),
        .keys  ({key_rotate, key_right, key_left}),
        .press (press)
    );

    assign lock_next = lock_cnt + 1'b1;

    // One extra bit catches the carry so the counters stick at all-ones
    assign score_sum  = {1'b0, score}
                      + {{(SCORE_W - 3){1'b0}}, score_for(clr_cnt)};
    assign lines_sum  = {1'b0, lines} + 1'b1;
    assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign lines_next = lines_sum[SCORE_W] ? '1 : lines_sum[SCORE_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            clear_board        <= 1'b0;
            load_block         <= 1'b0;
            move_down          <= 1'b0;
            move_left          <= 1'b0;
            move_right         <= 1'b0;
            rotate             <= 1'b0;
            update_board_state <= 1'b0;
            clear_row          <= 1'b0;
            scan_row           <= '0;
            score              <= '0;
            lines              <= '0;
            lock_cnt           <= '0;
            clr_cnt            <= '0;
            game_over          <= 1'b0;
        end else begin
            clear_board        <= 1'b0;
            load_block         <= 1'b0;
            move_down          <= 1'b0;
            move_left          <= 1'b0;
            move_right         <= 1'b0;
            rotate             <= 1'b0;
            update_board_state <= 1'b0;
            clear_row          <= 1'b0;
            unique case (state)
                IDLE, GAME_OVER: begin
                    if (start_game) begin
                        state       <= NEW;
                        clear_board <= 1'b1;
                        score       <= '0;
                        lines       <= '0;
                        game_over   <= 1'b0;
                    end
                end
                NEW: begin
                    state      <= SPAWN;
                    load_block <= 1'b1;
                end
                SPAWN: begin
                    if (spawn_blocked) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state    <= FALL;
                        lock_cnt <= '0;
                    end
                end
                FALL: begin
                    // Gravity wins the cycle; presses are single-shot,
                    // so a blocked or pre-empted one is simply lost
                    if (fall_tick) begin
                        if (!filled_under) begin
                            move_down <= 1'b1;
                            lock_cnt  <= '0;
                        end else if (lock_next == LOCK_MAX) begin
                            state              <= LOCK;
                            update_board_state <= 1'b1;
                            scan_row           <= '0;
                            clr_cnt            <= '0;
                            lock_cnt           <= '0;
                        end else begin
                            lock_cnt <= lock_next;
                        end
                    end else if (press[0]) begin
                        move_left <= !filled_left;
                    end else if (press[1]) begin
                        move_right <= !filled_right;
                    end else if (press[2]) begin
                        rotate <= !rotation_conflicts;
                    end
                end
                LOCK: begin
                    state <= SCAN;
                end
                SCAN: begin
                    if (row_full) begin
                        state     <= SETTLE;
                        clear_row <= 1'b1;
                        lines     <= lines_next;
                        if (clr_cnt != 3'd7) begin
                            clr_cnt <= clr_cnt + 3'd1;
                        end
                    end else if (scan_row != LAST_ROW) begin
                        scan_row <= scan_row + 1'b1;
                    end else begin
                        state <= SCORE;
                    end
                end
                SETTLE: begin
                    // Rescan the same row after the shift lands
                    state <= SCAN;
                end
                SCORE: begin
                    state      <= SPAWN;
                    score      <= score_next;
                    load_block <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_sequencer.sv
// Self-checking bench for tetris_sequencer: directed scenarios with
// literal expectations, then randomized play against a reference model.
module tb_tetris_sequencer;

    localparam int NROWS = 23;
    localparam int LTICKS = 2;
    localparam int SMAX = 65535;

    localparam bit [7:0] P_CB = 8'h80;
    localparam bit [7:0] P_LB = 8'h40;
    localparam bit [7:0] P_MD = 8'h20;
    localparam bit [7:0] P_ML = 8'h10;
    localparam bit [7:0] P_MR = 8'h08;
    localparam bit [7:0] P_RO = 8'h04;
    localparam bit [7:0] P_UB = 8'h02;
    localparam bit [7:0] P_CR = 8'h01;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_game = 1'b0;
    logic fall_tick = 1'b0;
    logic key_left = 1'b0;
    logic key_right = 1'b0;
    logic key_rotate = 1'b0;
    logic filled_under = 1'b0;
    logic filled_left = 1'b0;
    logic filled_right = 1'b0;
    logic rotation_conflicts = 1'b0;
    logic spawn_blocked = 1'b0;
    logic row_full;
    logic rf_rand = 1'b0;
    logic use_mask = 1'b0;
    logic mask_set = 1'b0;
    logic [31:0] mask_init = '0;
    logic [31:0] mask = '0;

    logic clear_board, load_block, move_down, move_left, move_right;
    logic rotate, update_board_state, clear_row, game_over;
    logic [4:0] scan_row;
    logic [15:0] score, lines;

    tetris_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .start_game         (start_game),
        .fall_tick          (fall_tick),
        .key_left           (key_left),
        .key_right          (key_right),
        .key_rotate         (key_rotate),
        .filled_under       (filled_under),
        .filled_left        (filled_left),
        .filled_right       (filled_right),
        .rotation_conflicts (rotation_conflicts),
        .spawn_blocked      (spawn_blocked),
        .row_full           (row_full),
        .clear_board        (clear_board),
        .load_block         (load_block),
        .move_down          (move_down),
        .move_left          (move_left),
        .move_right         (move_right),
        .rotate             (rotate),
        .update_board_state (update_board_state),
        .scan_row           (scan_row),
        .clear_row          (clear_row),
        .score              (score),
        .lines              (lines),
        .game_over          (game_over)
    );

    always #5 clock = ~clock;

    // Toy board: set bits are full rows; a clear deletes one and
    // drops everything above it by one row.
    assign row_full = use_mask ? mask[scan_row] : rf_rand;

    always @(posedge clock) begin
        if (mask_set) begin
            mask <= mask_init;
        end else if (clear_row) begin
            mask <= (mask & ((32'd1 << scan_row) - 32'd1))
                  | ((mask >> (32'(scan_row) + 32'd1)) << scan_row);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: phase of the piece life cycle plus game tallies
    typedef enum {
        M_IDLE, M_NEW, M_SPAWN, M_FALL, M_LOCK,
        M_SCAN, M_SETTLE, M_SCORE, M_OVER
    } mphase_t;

    mphase_t ph = M_IDLE;
    bit mvalid = 1'b0;
    int lk = 0, row = 0, kc = 0, sc = 0, ln = 0;
    bit go = 1'b0;
    bit [7:0] ep = '0;
    bit [2:0] kq = '0;
    int tab[5] = '{0, 1, 3, 5, 8};

    task automatic model_step();
        bit [2:0] kn, pr;
        kn = {key_rotate, key_right, key_left};
        ep = '0;
        if (reset) begin
            ph = M_IDLE; row = 0; sc = 0; ln = 0;
            lk = 0; kc = 0; go = 0; kq = '0; mvalid = 1'b1;
            return;
        end
        pr = kn & ~kq;
        kq = kn;
        case (ph)
            M_IDLE, M_OVER: if (start_game) begin
                ph = M_NEW; ep = P_CB; sc = 0; ln = 0; go = 0;
            end
            M_NEW: begin ph = M_SPAWN; ep = P_LB; end
            M_SPAWN: if (spawn_blocked) begin
                ph = M_OVER; go = 1;
            end else begin
                ph = M_FALL; lk = 0;
            end
            M_FALL: begin
                if (fall_tick) begin
                    if (!filled_under) begin
                        ep = P_MD; lk = 0;
                    end else begin
                        lk++;
                        if (lk == LTICKS) begin
                            ph = M_LOCK; ep = P_UB; row = 0; kc = 0;
                        end
                    end
                end else if (pr[0]) begin
                    if (!filled_left) ep = P_ML;
                end else if (pr[1]) begin
                    if (!filled_right) ep = P_MR;
                end else if (pr[2]) begin
                    if (!rotation_conflicts) ep = P_RO;
                end
            end
            M_LOCK: ph = M_SCAN;
            M_SCAN: begin
                if (row_full) begin
                    ep = P_CR; kc++; ph = M_SETTLE;
                    ln = (ln + 1 > SMAX) ? SMAX : ln + 1;
                end else if (row < NROWS - 1) begin
                    row++;
                end else begin
                    ph = M_SCORE;
                end
            end
            M_SETTLE: ph = M_SCAN;
            M_SCORE: begin
                sc = sc + tab[(kc > 4) ? 4 : kc];
                if (sc > SMAX) sc = SMAX;
                ph = M_SPAWN; ep = P_LB;
            end
            default: ph = M_IDLE;
        endcase
    endtask

    int n_lb = 0, n_md = 0, n_ml = 0, n_mr = 0, n_ro = 0;
    int n_ub = 0, n_cb = 0;
    int cr_rows[$];

    always begin
        @(posedge clock);
        model_step();
        #1;
        if (mvalid) begin
            chk("pulses", int'({clear_board, load_block, move_down,
                move_left, move_right, rotate,
                update_board_state, clear_row}), int'(ep));
            chk("scan_row", int'(scan_row), row);
            chk("score", int'(score), sc);
            chk("lines", int'(lines), ln);
            chk("game_over", int'(game_over), int'(go));
        end
        if (load_block) n_lb++;
        if (move_down) n_md++;
        if (move_left) n_ml++;
        if (move_right) n_mr++;
        if (rotate) n_ro++;
        if (update_board_state) n_ub++;
        if (clear_board) n_cb++;
        if (clear_row) cr_rows.push_back(int'(scan_row));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tick_once();
        @(negedge clock);
        fall_tick = 1'b1;
        @(negedge clock);
        fall_tick = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start_game = 1'b1;
        @(negedge clock);
        start_game = 1'b0;
    endtask

    task automatic load_mask(input logic [31:0] m);
        @(negedge clock);
        mask_init = m;
        mask_set = 1'b1;
        @(negedge clock);
        mask_set = 1'b0;
    endtask

    task automatic wait_lb(input int target, input string nm);
        int i;
        i = 0;
        while (n_lb < target && i < 200) begin
            @(negedge clock);
            i++;
        end
        chk(nm, int'(n_lb >= target), 1);
        cyc(2);
    endtask

    initial begin
        int b_md, b_ml, b_mr, b_ro, b_cb, b_cr, b_lb, i;
        int sc0, ln0;

        cyc(3);
        reset = 1'b0;
        chk("rst_score", int'(score), 0);
        chk("rst_lines", int'(lines), 0);
        chk("rst_scan_row", int'(scan_row), 0);
        chk("rst_game_over", int'(game_over), 0);

        // Start, spawn, three free-fall ticks
        pulse_start();
        cyc(4);
        b_md = n_md;
        repeat (3) tick_once();
        chk("t1_clear_board", n_cb, 1);
        chk("t1_load_once", n_lb, 1);
        chk("t1_move_down3", n_md - b_md, 3);
        chk("t1_no_lock", n_ub, 0);

        // Grounded: two ticks lock, full scan, nothing cleared
        filled_under = 1'b1;
        repeat (2) tick_once();
        wait_lb(2, "t2_respawn");
        chk("t2_lock_once", n_ub, 1);
        chk("t2_scan_end", int'(scan_row), NROWS - 1);
        chk("t2_score", int'(score), 0);
        chk("t2_no_clear", cr_rows.size(), 0);
        filled_under = 1'b0;

        // Held key acts once; blocked press dropped
        b_ml = n_ml;
        @(negedge clock);
        key_left = 1'b1;
        cyc(10);
        key_left = 1'b0;
        chk("t3_left_once", n_ml - b_ml, 1);
        b_mr = n_mr;
        filled_right = 1'b1;
        @(negedge clock);
        key_right = 1'b1;
        cyc(3);
        key_right = 1'b0;
        filled_right = 1'b0;
        cyc(1);
        chk("t3_right_blocked", n_mr - b_mr, 0);
        b_ro = n_ro;
        @(negedge clock);
        key_rotate = 1'b1;
        cyc(2);
        key_rotate = 1'b0;
        chk("t3_rotate_once", n_ro - b_ro, 1);

        // Rows 0,1,3 full: clears at rows 0, 0, 1
        b_cr = cr_rows.size();
        sc0 = int'(score);
        ln0 = int'(lines);
        load_mask(32'b1011);
        use_mask = 1'b1;
        filled_under = 1'b1;
        repeat (2) tick_once();
        wait_lb(3, "t4_respawn");
        use_mask = 1'b0;
        chk("t4_clear_count", cr_rows.size() - b_cr, 3);
        if (cr_rows.size() - b_cr == 3) begin
            chk("t4_row_a", cr_rows[b_cr], 0);
            chk("t4_row_b", cr_rows[b_cr + 1], 0);
            chk("t4_row_c", cr_rows[b_cr + 2], 1);
        end
        chk("t4_lines", int'(lines) - ln0, 3);
        chk("t4_score", int'(score) - sc0, 5);

        // Reset in the middle of a scan
        repeat (2) tick_once();
        i = 0;
        while (scan_row != 5'd7 && i < 100) begin
            @(negedge clock);
            i++;
        end
        chk("t5_reach_row7", int'(scan_row), 7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_scan_row", int'(scan_row), 0);
        chk("t5_score", int'(score), 0);
        chk("t5_lines", int'(lines), 0);
        chk("t5_pulses", int'({clear_board, load_block, move_down,
            move_left, move_right, rotate,
            update_board_state, clear_row}), 0);
        b_cb = n_cb;
        b_lb = n_lb;
        cyc(3);
        chk("t5_idle_hold", (n_cb - b_cb) + (n_lb - b_lb), 0);
        filled_under = 1'b0;

        // One row cleared, then spawn blocked -> game over, restart
        pulse_start();
        wait_lb(b_lb + 1, "t6_spawn");
        b_lb = n_lb;
        load_mask(32'b1);
        use_mask = 1'b1;
        spawn_blocked = 1'b1;
        filled_under = 1'b1;
        repeat (2) tick_once();
        i = 0;
        while (!game_over && i < 100) begin
            @(negedge clock);
            i++;
        end
        chk("t6_game_over", int'(game_over), 1);
        chk("t6_score_held", int'(score), 1);
        chk("t6_lines_held", int'(lines), 1);
        use_mask = 1'b0;
        spawn_blocked = 1'b0;
        filled_under = 1'b0;
        cyc(3);
        pulse_start();
        chk("t6_clear_board", int'(clear_board), 1);
        chk("t6_score_zero", int'(score), 0);
        chk("t6_go_low", int'(game_over), 0);
        @(negedge clock);
        chk("t6_load_block", int'(load_block), 1);

        // Randomized play
        repeat (4000) begin
            @(negedge clock);
            reset = ($urandom_range(0, 299) == 0);
            start_game = ($urandom_range(0, 15) == 0);
            fall_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) key_left = ~key_left;
            if ($urandom_range(0, 5) == 0) key_right = ~key_right;
            if ($urandom_range(0, 5) == 0) key_rotate = ~key_rotate;
            filled_under = ($urandom_range(0, 2) == 0);
            filled_left = ($urandom_range(0, 2) == 0);
            filled_right = ($urandom_range(0, 2) == 0);
            rotation_conflicts = ($urandom_range(0, 2) == 0);
            spawn_blocked = ($urandom_range(0, 19) == 0);
            rf_rand = ($urandom_range(0, 9) == 0);
        end
        @(negedge clock);
        reset = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
